// File: rtl/linebuf_pkg.sv
// Shared constants and pixel helpers for the ping-pong line buffer.
// The optional luma output is controlled by the LINEBUF_LUMA_EN macro.
package linebuf_pkg;

    localparam int NUM_BANKS  = 2;

    // BT.601-style luma weights in 1/256 units.
    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic int pix_word_w(input int pix_w);
        return 3 * pix_w;
    endfunction

endpackage

// File: rtl/line_buf_pingpong_if.sv
// Pixel-write and scan-out read bundle for line_buf_pingpong.
// luma_pix exists only when LINEBUF_LUMA_EN is defined.
interface line_buf_pingpong_if #(
    parameter int DEPTH = 100,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(DEPTH)
);
    // Write side: a pixel transfers on a clock edge where wr_valid && wr_ready;
    // wr_ready depends only on registers, and wr_valid while !wr_ready is an overrun.
    logic               wr_valid;
    logic [3*PIX_W-1:0] wr_data;
    logic               wr_ready;
    logic [AW-1:0]      wr_row;

    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic               rd_done;
    logic [PIX_W-1:0]   red_pix;
    logic [PIX_W-1:0]   green_pix;
    logic [PIX_W-1:0]   blue_pix;
    logic               rd_valid;
    logic               line_ready;
    logic               overrun;
`ifdef LINEBUF_LUMA_EN
    logic [PIX_W-1:0]   luma_pix;
`endif

    modport master (
        output wr_valid, wr_data, rd_en, rd_addr, rd_done,
        input  wr_ready, wr_row, red_pix, green_pix, blue_pix,
               rd_valid, line_ready, overrun
`ifdef LINEBUF_LUMA_EN
        , input luma_pix
`endif
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, rd_addr, rd_done,
        output wr_ready, wr_row, red_pix, green_pix, blue_pix,
               rd_valid, line_ready, overrun
`ifdef LINEBUF_LUMA_EN
        , output luma_pix
`endif
    );

endinterface

// File: rtl/linebuf_bank_ram.sv
// One line bank: synchronous write, registered read; the read register holds
// its value between reads so the top can present stable pixels.
module linebuf_bank_ram #(
    parameter int DEPTH = 100,
    parameter int W     = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; array contents are left undefined.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buf_pingpong.sv
// Double-buffered RGB line store: writer fills one bank while the reader scans
// the other; banks swap on last-pixel / rd_done. Optional luma: LINEBUF_LUMA_EN.
module line_buf_pingpong
    import linebuf_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic                clock,
    input logic                reset,
    line_buf_pingpong_if.slave bus
);

    localparam int            WW      = pix_word_w(PIX_W);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic                 wr_bank;
    logic                 rd_bank;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        wr_row_q;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_nxt;
    logic                 overrun_q;
    logic                 rd_valid_q;
    logic                 sel_q;
    logic                 zero_q;

    logic                 wr_ready;
    logic                 line_ready;
    logic                 accept;
    logic                 last_wr;
    logic                 rd_fire;
    logic                 rd_in_range;
    logic                 rd_release;
    logic [WW-1:0]        bank_q [NUM_BANKS];
    logic [WW-1:0]        rgb;

    assign wr_ready    = !full[wr_bank];
    assign line_ready  = full[rd_bank];
    assign accept      = bus.wr_valid && wr_ready;
    assign last_wr     = (wr_idx == LAST);
    assign rd_fire     = bus.rd_en && line_ready;
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign rd_release  = bus.rd_done && line_ready;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        linebuf_bank_ram #(.DEPTH(DEPTH), .W(WW), .AW(AW)) u_ram (
            .clock (clock),
            .reset (reset),
            .we    (accept && (wr_bank == 1'(b))),
            .waddr (wr_idx),
            .wdata (bus.wr_data),
            .re    (rd_fire && rd_in_range && (rd_bank == 1'(b))),
            .raddr (bus.rd_addr),
            .rdata (bank_q[b])
        );
    end

    // The last write and an accepted rd_done always address different banks.
    always_comb begin
        full_nxt = full;
        if (accept && last_wr) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_release) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            wr_row_q   <= '0;
            full       <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            sel_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            full       <= full_nxt;
            rd_valid_q <= rd_fire;
            if (accept) begin
                wr_row_q <= wr_idx;
                wr_idx   <= last_wr ? '0 : wr_idx + 1'b1;
                if (last_wr) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (bus.wr_valid && !wr_ready) begin
                overrun_q <= 1'b1;
            end
            if (rd_release) begin
                rd_bank <= !rd_bank;
            end
            // sel_q/zero_q only move on an accepted read, so rgb holds otherwise.
            if (rd_fire) begin
                sel_q  <= rd_bank;
                zero_q <= !rd_in_range;
            end
        end
    end

    assign rgb = zero_q ? '0 : bank_q[sel_q];

    assign bus.wr_ready   = wr_ready;
    assign bus.wr_row     = wr_row_q;
    assign bus.line_ready = line_ready;
    assign bus.overrun    = overrun_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.red_pix    = rgb[3*PIX_W-1:2*PIX_W];
    assign bus.green_pix  = rgb[2*PIX_W-1:PIX_W];
    assign bus.blue_pix   = rgb[PIX_W-1:0];

`ifdef LINEBUF_LUMA_EN
    localparam int LW = 16 + PIX_W;
    logic [LW-1:0] luma_acc;

    // Derived from the registered rgb word, so it tracks rd_valid and resets to 0.
    assign luma_acc = LW'(LUMA_R) * LW'(rgb[3*PIX_W-1:2*PIX_W])
                    + LW'(LUMA_G) * LW'(rgb[2*PIX_W-1:PIX_W])
                    + LW'(LUMA_B) * LW'(rgb[PIX_W-1:0]);
    assign bus.luma_pix = luma_acc[LUMA_SHIFT +: PIX_W];
`endif

endmodule

// File: tb/tb_line_buf_pingpong.sv
// Directed bench for line_buf_pingpong: fill/swap, overrun, reset mid-line,
// out-of-range and ignored reads; luma checks when LINEBUF_LUMA_EN is defined.
module tb_line_buf_pingpong;

    localparam int DEPTH = 100;
    localparam int PIX_W = 8;
    localparam int AW    = $clog2(DEPTH);

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    line_buf_pingpong_if #(.DEPTH(DEPTH), .PIX_W(PIX_W)) bus ();

    line_buf_pingpong #(.DEPTH(DEPTH), .PIX_W(PIX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_done  = 1'b0;
        reset        = 1'b1;
        step();
        step();
        reset        = 1'b0;
    endtask

    task automatic write_pix(input logic [23:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_pix(input logic [AW-1:0] addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        step();
        bus.rd_en   = 1'b0;
    endtask

    task automatic pulse_done();
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
    endtask

    function automatic logic [23:0] rgb_out();
        return {bus.red_pix, bus.green_pix, bus.blue_pix};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_wr_row", 32'(bus.wr_row), 32'd0);
        check("rst_line_ready", 32'(bus.line_ready), 32'd0);
        check("rst_rgb", 32'(rgb_out()), 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // 1: first line into bank 0
        for (int i = 0; i < DEPTH; i++) begin
            write_pix(24'(i + 1));
            check("t1_wr_row", 32'(bus.wr_row), 32'(i));
            if (i == DEPTH - 2) check("t1_line_ready_early", 32'(bus.line_ready), 32'd0);
        end
        check("t1_line_ready", 32'(bus.line_ready), 32'd1);
        read_pix(AW'(5));
        check("t1_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t1_rgb_addr5", 32'(rgb_out()), 32'h000006);
        step();
        check("t1_rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        check("t1_rgb_hold", 32'(rgb_out()), 32'h000006);

        // 2: second line fills bank 1, then writer stalls
        for (int i = 0; i < DEPTH; i++) begin
            write_pix(24'(DEPTH + i + 1));
        end
        check("t2_wr_ready_low", 32'(bus.wr_ready), 32'd0);
        check("t2_overrun_before", 32'(bus.overrun), 32'd0);
        write_pix(24'hDEAD00);
        check("t2_overrun", 32'(bus.overrun), 32'd1);
        check("t2_wr_row_frozen", 32'(bus.wr_row), 32'd99);
        read_pix(AW'(0));
        check("t2_bank0_addr0", 32'(rgb_out()), 32'h000001);
        read_pix(AW'(99));
        check("t2_bank0_addr99", 32'(rgb_out()), 32'h000064);

        // 3: release bank 0, read bank 1, writer resumes at bank 0 index 0
        pulse_done();
        check("t3_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("t3_line_ready", 32'(bus.line_ready), 32'd1);
        read_pix(AW'(0));
        check("t3_bank1_addr0", 32'(rgb_out()), 32'h000065);
        read_pix(AW'(99));
        check("t3_bank1_addr99", 32'(rgb_out()), 32'h0000C8);
        write_pix(24'hABCDEF);
        check("t3_wr_row", 32'(bus.wr_row), 32'd0);
        check("t3_overrun_sticky", 32'(bus.overrun), 32'd1);

        // 4: reset mid-line discards everything
        do_reset();
        for (int i = 0; i < 50; i++) write_pix(24'h300000 + 24'(i));
        check("t4_wr_row_50", 32'(bus.wr_row), 32'd49);
        do_reset();
        check("t4_wr_row", 32'(bus.wr_row), 32'd0);
        check("t4_line_ready", 32'(bus.line_ready), 32'd0);
        check("t4_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            write_pix(24'h100000 + 24'(i));
            if (i == DEPTH - 2) check("t4_line_ready_99", 32'(bus.line_ready), 32'd0);
        end
        check("t4_line_ready_100", 32'(bus.line_ready), 32'd1);

        // 5: out-of-range and ignored reads / done
        read_pix(AW'(120));
        check("t5_oor_valid", 32'(bus.rd_valid), 32'd1);
        check("t5_oor_rgb", 32'(rgb_out()), 32'h0);
        read_pix(AW'(7));
        check("t5_addr7", 32'(rgb_out()), 32'h100007);
        pulse_done();
        check("t5_line_ready_off", 32'(bus.line_ready), 32'd0);
        read_pix(AW'(3));
        check("t5_noline_valid", 32'(bus.rd_valid), 32'd0);
        check("t5_noline_rgb", 32'(rgb_out()), 32'h100007);
        pulse_done();
        check("t5_done_ignored", 32'(bus.line_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) write_pix(24'h200000 + 24'(i));
        check("t5_bank1_ready", 32'(bus.line_ready), 32'd1);
        check("t5_wr_ready", 32'(bus.wr_ready), 32'd1);
        read_pix(AW'(4));
        check("t5_bank1_addr4", 32'(rgb_out()), 32'h200004);

`ifdef LINEBUF_LUMA_EN
        // 6: luma
        do_reset();
        check("t6_luma_rst", 32'(bus.luma_pix), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0)      write_pix(24'hFFFFFF);
            else if (i == 1) write_pix(24'h800000);
            else             write_pix(24'h000000);
        end
        read_pix(AW'(0));
        check("t6_luma_white", 32'(bus.luma_pix), 32'hFF);
        read_pix(AW'(1));
        check("t6_luma_red", 32'(bus.luma_pix), 32'h26);
        read_pix(AW'(2));
        check("t6_luma_black", 32'(bus.luma_pix), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
